// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM among NUM_REQ pixel requesters.
// Optional ARB_BOUNDS_CHECK_EN: out-of-image addresses skip the ROM and return a transparent zero pixel.
module sprite_rom_arbiter #(
    parameter int             NUM_REQ           = 4,
    parameter int             AW                = 16,
    parameter int             DW                = 8,
    parameter int             ROM_LATENCY       = 1,
    parameter int             IMAGE_SIZE        = 23550,
    parameter logic [DW-1:0]  TRANSPARENT_COLOR = 8'hE3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [AW-1:0]         rom_addr,
    input  logic [DW-1:0]         rom_q,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]         rsp_data,
    output logic                  rsp_visible,
    output logic                  busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int L  = ROM_LATENCY;

    logic [PW-1:0]                 last_ptr_q, last_ptr_d;
    logic [AW-1:0]                 rom_addr_q, rom_addr_d;
    logic [L:0]                    tag_vld_q, tag_vld_d;
    logic [L:0][NUM_REQ-1:0]       tag_oh_q, tag_oh_d;
    logic [L:0]                    tag_oob_q, tag_oob_d;
    logic [NUM_REQ-1:0]            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]                 rsp_data_q, rsp_data_d;
    logic                          rsp_visible_q, rsp_visible_d;
    logic                          busy_q, busy_d;

    logic [PW-1:0]                 gnt_idx;
    logic [PW-1:0]                 scan_idx;
    logic                          gnt_found;
    logic [AW-1:0]                 sel_addr;
    logic                          acc_oob;

    // Search begins just after the last accepted requester, wrapping around.
    always_comb begin
        gnt_idx   = '0;
        gnt_found = 1'b0;
        scan_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = PW'((int'(last_ptr_q) + k) % NUM_REQ);
            if (!gnt_found && req[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (gnt_found) begin
            gnt = NUM_REQ'(1) << gnt_idx;
        end
    end

    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*AW +: AW];
            end
        end
    end

`ifdef ARB_BOUNDS_CHECK_EN
    localparam logic [AW:0] IMG_LIMIT = (AW+1)'(IMAGE_SIZE);
    always_comb begin
        acc_oob = gnt_found && ({1'b0, sel_addr} >= IMG_LIMIT);
    end
`else
    always_comb begin
        acc_oob = 1'b0;
    end
`endif

    always_comb begin
        last_ptr_d = last_ptr_q;
        rom_addr_d = rom_addr_q;
        if (gnt_found) begin
            last_ptr_d = gnt_idx;
            if (!acc_oob) begin
                rom_addr_d = sel_addr;
            end
        end

        tag_vld_d = {tag_vld_q[L-1:0], gnt_found};
        tag_oh_d  = {tag_oh_q[L-1:0], gnt};
        tag_oob_d = {tag_oob_q[L-1:0], acc_oob};

        // The last tag stage lines up with rom_q for the read it describes.
        rsp_valid_d   = '0;
        rsp_data_d    = '0;
        rsp_visible_d = 1'b0;
        if (tag_vld_q[L]) begin
            rsp_valid_d = tag_oh_q[L];
            if (!tag_oob_q[L]) begin
                rsp_data_d    = rom_q;
                rsp_visible_d = (rom_q != TRANSPARENT_COLOR);
            end
        end

        busy_d = (|tag_vld_d) | (|rsp_valid_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_ptr_q    <= PW'(NUM_REQ - 1);
            rom_addr_q    <= '0;
            tag_vld_q     <= '0;
            tag_oh_q      <= '0;
            tag_oob_q     <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            rsp_visible_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            last_ptr_q    <= last_ptr_d;
            rom_addr_q    <= rom_addr_d;
            tag_vld_q     <= tag_vld_d;
            tag_oh_q      <= tag_oh_d;
            tag_oob_q     <= tag_oob_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_visible_q <= rsp_visible_d;
            busy_q        <= busy_d;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_visible = rsp_visible_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Randomized bench for sprite_rom_arbiter against a cycle-indexed behavioural model.
// Build with ARB_BOUNDS_CHECK_EN defined to exercise the out-of-image path.
module tb_sprite_rom_arbiter;

    localparam int NR  = 4;
    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int IMG = 23550;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*AW-1:0]  req_addr;
    logic [NR-1:0]     gnt;
    logic [AW-1:0]     rom_addr;
    logic [DW-1:0]     rom_q = '0;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              rsp_visible;
    logic              busy;

    sprite_rom_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_addr    (req_addr),
        .gnt         (gnt),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_visible (rsp_visible),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_val(input logic [15:0] a);
        if (a == 16'd100) return 8'h1C;
        if (a == 16'd5)   return 8'hE3;
        return 8'((a * 7) ^ (a >> 5));
    endfunction

    // Synchronous ROM, one cycle of latency.
    always @(posedge clk) rom_q <= rom_val(rom_addr);

    int              cyc;
    int              last;
    int              n_checks;
    int              n_pass;
    int              exp_ridx [int];
    logic [7:0]      exp_rdat [int];
    bit              exp_rvis [int];
    bit              exp_busy [int];
    logic [15:0]     rom_upd  [int];
    logic [15:0]     exp_rom_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    endtask

    function automatic logic [63:0] mk(input logic [15:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic model_reset();
        exp_ridx.delete();
        exp_rdat.delete();
        exp_rvis.delete();
        exp_busy.delete();
        rom_upd.delete();
        last         = NR - 1;
        exp_rom_addr = '0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt"},      32'(gnt),         32'd0);
        chk({tag, "_rsp_v"},    32'(rsp_valid),   32'd0);
        chk({tag, "_rsp_d"},    32'(rsp_data),    32'd0);
        chk({tag, "_rsp_vis"},  32'(rsp_visible), 32'd0);
        chk({tag, "_busy"},     32'(busy),        32'd0);
        chk({tag, "_rom_addr"}, 32'(rom_addr),    32'd0);
    endtask

    task automatic step(input logic [NR-1:0] r, input logic [NR*AW-1:0] a, output int gidx);
        logic [15:0] addr;
        logic [7:0]  dat;
        bit          oob;
        @(posedge clk);
        cyc++;
        #1;
        req      = r;
        req_addr = a;
        #1;
        if (rom_upd.exists(cyc)) exp_rom_addr = rom_upd[cyc];
        chk("rom_addr", 32'(rom_addr), 32'(exp_rom_addr));
        chk("busy", 32'(busy), 32'(exp_busy.exists(cyc)));
        if (exp_ridx.exists(cyc)) begin
            chk("rsp_valid",   32'(rsp_valid),   32'(1 << exp_ridx[cyc]));
            chk("rsp_data",    32'(rsp_data),    32'(exp_rdat[cyc]));
            chk("rsp_visible", 32'(rsp_visible), 32'(exp_rvis[cyc]));
        end else begin
            chk("rsp_valid_idle",   32'(rsp_valid),   32'd0);
            chk("rsp_data_idle",    32'(rsp_data),    32'd0);
            chk("rsp_visible_idle", 32'(rsp_visible), 32'd0);
        end
        gidx = -1;
        for (int k = 1; k <= NR; k++) begin
            if (gidx < 0 && r[(last + k) % NR]) gidx = (last + k) % NR;
        end
        chk("gnt", 32'(gnt), (gidx < 0) ? 32'd0 : 32'(1 << gidx));
        if (gidx >= 0) begin
            last = gidx;
            addr = a[gidx*AW +: AW];
`ifdef ARB_BOUNDS_CHECK_EN
            oob = (int'(addr) >= IMG);
`else
            oob = 1'b0;
`endif
            if (!oob) rom_upd[cyc + 1] = addr;
            dat = oob ? 8'h00 : rom_val(addr);
            exp_ridx[cyc + 3] = gidx;
            exp_rdat[cyc + 3] = dat;
            exp_rvis[cyc + 3] = !oob && (dat != 8'hE3);
            for (int d = 1; d <= 3; d++) exp_busy[cyc + d] = 1'b1;
        end
    endtask

    task automatic reset_mid();
        req = '0;
        rst = 1'b1;
        #1;
        check_zero("rst_mid");
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic idle(input int n);
        int g;
        for (int i = 0; i < n; i++) step('0, '0, g);
    endtask

    bit          pend  [NR];
    logic [15:0] paddr [NR];

    initial begin
        int g;
        logic [NR-1:0]    r;
        logic [NR*AW-1:0] a;
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        rst      = 1'b1;
        req      = '0;
        req_addr = '0;
        model_reset();
        #2;
        check_zero("rst_init");
        @(posedge clk);
        #3 rst = 1'b0;

        step(4'b0001, mk(16'd100, 16'd0, 16'd0, 16'd0), g);
        idle(4);

        reset_mid();
        for (int i = 0; i < 8; i++) step(4'b1111, mk(16'd10, 16'd20, 16'd30, 16'd40), g);
        idle(4);

        step(4'b0001, mk(16'd5, 16'd0, 16'd0, 16'd0), g);
        idle(3);

        step(4'b0001, mk(16'd7, 16'd0, 16'd0, 16'd0), g);
        step(4'b0101, mk(16'd1, 16'd0, 16'd2, 16'd0), g);
        step(4'b0001, mk(16'd3, 16'd0, 16'd0, 16'd0), g);
        idle(3);

        step(4'b0011, mk(16'd11, 16'd12, 16'd0, 16'd0), g);
        step(4'b0011, mk(16'd11, 16'd12, 16'd0, 16'd0), g);
        step('0, '0, g);
        reset_mid();
        idle(5);

        step(4'b0001, mk(16'd1234, 16'd0, 16'd0, 16'd0), g);
        step(4'b0001, mk(16'd23550, 16'd0, 16'd0, 16'd0), g);
        idle(4);

        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 40) begin
                    pend[i]  = 1'b1;
                    paddr[i] = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(IMG, 65535))
                                                           : 16'($urandom_range(0, IMG - 1));
                end else if (pend[i] && $urandom_range(0, 99) < 3) begin
                    pend[i] = 1'b0;
                end
                r[i]           = pend[i];
                a[i*AW +: AW]  = paddr[i];
            end
            step(r, a, g);
            if (g >= 0) pend[g] = 1'b0;
        end
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
